mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe_pkg.sv | 21 ++
 rtl/mem_wb_entry.sv | 39 +++
 rtl/mem_wb_pipe.sv | 146 ++++++++++++++
 tb/tb_mem_wb_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// +--------------------------------------------------------------------+
// | mem_wb_pipe_pkg : shared FSM encodings and constants for MEM/WB    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_wb_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } mem_wb_state_t;

  localparam int          ZR_ADDR_DEFAULT = 31;
  localparam logic        RstEnable       = 1'b1;
  localparam logic [63:0] ZeroWord        = 64'h0;

endpackage

`default_nettype wire

// File: rtl/mem_wb_entry.sv
// +--------------------------------------------------------------------+
// | mem_wb_entry : one loadable write-back entry (wdata/waddr/regwrite)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_wb_entry
  import mem_wb_pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [RA_W-1:0] d_waddr,
  input  logic            d_regwrite,
  output logic [XLEN-1:0] q_wdata,
  output logic [RA_W-1:0] q_waddr,
  output logic            q_regwrite
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      q_wdata    <= XLEN'(ZeroWord);
      q_waddr    <= '0;
      q_regwrite <= 1'b0;
    end else if (load) begin
      q_wdata    <= d_wdata;
      q_waddr    <= d_waddr;
      q_regwrite <= d_regwrite;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// +--------------------------------------------------------------------+
// | mem_wb_pipe : 2-entry MEM->WB skid pipeline, optional forwarding   |
// | ports under MEM_WB_FWD_EN.                                  Rev 1.0|
// +--------------------------------------------------------------------+
`default_nettype none

module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RA_W    = 5,
  parameter int ZR_ADDR = ZR_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rdata,
  input  logic [XLEN-1:0] in_result,
  input  logic [RA_W-1:0] in_waddr,
  input  logic            in_memtoreg,
  input  logic            in_regwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wdata,
  output logic [RA_W-1:0] out_waddr,
  output logic            out_we
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [RA_W-1:0] fwd_raddr_a,
  input  logic [RA_W-1:0] fwd_raddr_b,
  output logic            fwd_hit_a,
  output logic            fwd_hit_b,
  output logic [XLEN-1:0] fwd_data
`endif
);

  mem_wb_state_t   state, state_nxt;
  logic            ready_q;
  logic            enq, deq;
  logic            main_load, skid_load, main_from_skid;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] main_d_wdata, main_wdata, skid_wdata;
  logic [RA_W-1:0] main_d_waddr, main_waddr, skid_waddr;
  logic            main_d_rw, main_rw, skid_rw;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = ready_q;
  assign enq       = in_valid & ready_q;
  assign deq       = out_valid & out_ready;

  // Mux at enqueue so each entry carries only the final write-back data.
  assign in_wdata = in_memtoreg ? in_rdata : in_result;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (enq) begin
            main_load = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (enq && deq) begin
            main_load = 1'b1;
          end else if (enq) begin
            skid_load = 1'b1;
            state_nxt = ST_FULL;
          end else if (deq) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deq) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      // Registered so in_ready has no combinational path from out_ready.
      ready_q <= (state_nxt != ST_FULL);
    end
  end

  assign main_d_wdata = main_from_skid ? skid_wdata : in_wdata;
  assign main_d_waddr = main_from_skid ? skid_waddr : in_waddr;
  assign main_d_rw    = main_from_skid ? skid_rw    : in_regwrite;

  mem_wb_entry #(.XLEN(XLEN), .RA_W(RA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .load       (main_load),
    .d_wdata    (main_d_wdata),
    .d_waddr    (main_d_waddr),
    .d_regwrite (main_d_rw),
    .q_wdata    (main_wdata),
    .q_waddr    (main_waddr),
    .q_regwrite (main_rw)
  );

  mem_wb_entry #(.XLEN(XLEN), .RA_W(RA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .load       (skid_load),
    .d_wdata    (in_wdata),
    .d_waddr    (in_waddr),
    .d_regwrite (in_regwrite),
    .q_wdata    (skid_wdata),
    .q_waddr    (skid_waddr),
    .q_regwrite (skid_rw)
  );

  assign out_wdata = out_valid ? main_wdata : XLEN'(ZeroWord);
  assign out_waddr = out_valid ? main_waddr : '0;
  assign out_we    = out_valid & main_rw & (main_waddr != RA_W'(ZR_ADDR));

`ifdef MEM_WB_FWD_EN
  assign fwd_hit_a = out_we & (out_waddr == fwd_raddr_a);
  assign fwd_hit_b = out_we & (out_waddr == fwd_raddr_b);
  assign fwd_data  = out_wdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios then random traffic, all checked
// against a queue-based model of a 2-deep FIFO with flush/reset.
`default_nettype none

module tb_mem_wb_pipe;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_memtoreg, in_regwrite, out_ready;
  logic [XLEN-1:0] in_rdata, in_result;
  logic [RA_W-1:0] in_waddr;
  logic            in_ready, out_valid, out_we;
  logic [XLEN-1:0] out_wdata;
  logic [RA_W-1:0] out_waddr;
`ifdef MEM_WB_FWD_EN
  logic [RA_W-1:0] fwd_raddr_a, fwd_raddr_b;
  logic            fwd_hit_a, fwd_hit_b;
  logic [XLEN-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rdata    (in_rdata),
    .in_result   (in_result),
    .in_waddr    (in_waddr),
    .in_memtoreg (in_memtoreg),
    .in_regwrite (in_regwrite),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wdata   (out_wdata),
    .out_waddr   (out_waddr),
    .out_we      (out_we)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_raddr_a (fwd_raddr_a),
    .fwd_raddr_b (fwd_raddr_b),
    .fwd_hit_a   (fwd_hit_a),
    .fwd_hit_b   (fwd_hit_b),
    .fwd_data    (fwd_data)
`endif
  );

  typedef struct {
    logic [XLEN-1:0] wdata;
    logic [RA_W-1:0] waddr;
    logic            rw;
  } entry_t;

  entry_t model_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  bit     known = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs with the model's view of the 2-deep FIFO.
  task automatic check_outputs(input logic [RA_W-1:0] fa, input logic [RA_W-1:0] fb);
    logic [XLEN-1:0] e_wdata;
    logic [RA_W-1:0] e_waddr;
    logic            e_valid, e_we;
    e_valid = (model_q.size() > 0);
    e_wdata = e_valid ? model_q[0].wdata : '0;
    e_waddr = e_valid ? model_q[0].waddr : '0;
    e_we    = e_valid && model_q[0].rw && (model_q[0].waddr != 5'd31);
    chk("out_valid", XLEN'(out_valid), XLEN'(e_valid));
    chk("in_ready",  XLEN'(in_ready),  XLEN'(model_q.size() < 2));
    chk("out_wdata", out_wdata, e_wdata);
    chk("out_waddr", XLEN'(out_waddr), XLEN'(e_waddr));
    chk("out_we",    XLEN'(out_we),    XLEN'(e_we));
`ifdef MEM_WB_FWD_EN
    chk("fwd_hit_a", XLEN'(fwd_hit_a), XLEN'(e_we && (e_waddr == fa)));
    chk("fwd_hit_b", XLEN'(fwd_hit_b), XLEN'(e_we && (e_waddr == fb)));
    chk("fwd_data",  fwd_data, e_wdata);
`else
    if (fa == fb) begin end
`endif
  endtask

  // One clock: drive inputs, check the pre-edge outputs, advance the model.
  task automatic step(input bit iv, input logic [XLEN-1:0] rd, input logic [XLEN-1:0] res,
                      input logic [RA_W-1:0] wa, input bit m2r, input bit rw,
                      input bit ordy, input bit fl, input bit r,
                      input logic [RA_W-1:0] fa, input logic [RA_W-1:0] fb);
    entry_t e;
    bit     rdy;
    in_valid = iv; in_rdata = rd; in_result = res; in_waddr = wa;
    in_memtoreg = m2r; in_regwrite = rw; out_ready = ordy; flush = fl; rst = r;
`ifdef MEM_WB_FWD_EN
    fwd_raddr_a = fa; fwd_raddr_b = fb;
`endif
    #1;
    if (known) check_outputs(fa, fb);
    if (r || fl) begin
      model_q.delete();
    end else begin
      rdy = (model_q.size() < 2);
      if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
      if (iv && rdy) begin
        e.wdata = m2r ? rd : res;
        e.waddr = wa;
        e.rw    = rw;
        model_q.push_back(e);
      end
    end
    if (r) known = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_memtoreg = 0; in_regwrite = 0; out_ready = 0;
    in_rdata = '0; in_result = '0; in_waddr = '0;
`ifdef MEM_WB_FWD_EN
    fwd_raddr_a = '0; fwd_raddr_b = '0;
`endif
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Streaming: continuous enqueue and dequeue
    for (int i = 0; i < 6; i++) step(1, 64'h55, 64'h8, 5'd3, 0, 1, 1, 0, 0, 3, 4);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Backpressure to FULL, then drain in order
    step(1, 0, 64'h7, 5'd1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 64'h9, 5'd2, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 64'hDEAD, 5'd4, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Mux select and zero-register suppression
    step(1, 64'hAA, 64'hBB, 5'd31, 1, 1, 0, 0, 0, 31, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 31, 0);

    // Flush while FULL with a same-cycle enqueue
    step(1, 0, 64'h11, 5'd6, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 64'h22, 5'd7, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 64'h33, 5'd8, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset mid-stream, then normal traffic resumes
    step(1, 0, 64'h44, 5'd9, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 64'h45, 5'd9, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 64'h66, 5'd10, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Forwarding hit on port a only
    step(1, 0, 64'h1234, 5'd5, 0, 1, 0, 0, 0, 5, 6);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 6);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, {$urandom, $urandom},
           RA_W'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
           RA_W'($urandom_range(0, 31)), RA_W'($urandom_range(0, 31)));
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
